// File: rtl/aes256_encipher_iter.sv
// Iterative AES-256 encipher: one round per clock, key schedule expanded on the fly
// through a 256-bit sliding window (no stored round-key array).
module aes256_encipher_iter #(
    parameter int unsigned NR = 14
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] datain,
    input  logic [255:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] dataout
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e         state_q, state_d;
    logic [127:0]   st_q, st_d, dataout_q, dataout_d, rnd_out;
    logic [255:0]   kwin_q, kwin_d;
    logic [3:0]     rnd_q, rnd_d, rcon_idx_q, rcon_idx_d;
    logic [7:0]     sr [16];
    logic [7:0]     mc [16];
    logic [7:0]     a0, a1, a2, a3, rcon;
    logic [31:0]    t, tin, tsub, w0, w1, w2, w3;
    logic           last;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse as b^254 (square-and-multiply), then the affine map; 0 maps to 0 naturally.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] sq, inv;
        sq  = b;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    assign last = (rnd_q == 4'(NR));

    // Round datapath: SubBytes+ShiftRows, optional MixColumns, AddRoundKey
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[4*c+r] = sbox(st_q[127-8*(4*((c+r)%4)+r) -: 8]);
            end
        end
        for (int c = 0; c < 4; c++) begin
            a0 = sr[4*c];
            a1 = sr[4*c+1];
            a2 = sr[4*c+2];
            a3 = sr[4*c+3];
            mc[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            mc[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            mc[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            mc[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        rnd_out = kwin_q[127:0];
        for (int n = 0; n < 16; n++) begin
            rnd_out[127-8*n -: 8] = rnd_out[127-8*n -: 8] ^ (last ? sr[n] : mc[n]);
        end
    end

    // Next four schedule words; odd rounds take RotWord+Rcon, even rounds plain SubWord
    always_comb begin
        rcon = 8'h01 << (rcon_idx_q - 4'd1);
        t    = kwin_q[31:0];
        tin  = rnd_q[0] ? {t[23:0], t[31:24]} : t;
        tsub = {sbox(tin[31:24]), sbox(tin[23:16]), sbox(tin[15:8]), sbox(tin[7:0])};
        if (rnd_q[0]) tsub = tsub ^ {rcon, 24'h0};
        w0 = kwin_q[255:224] ^ tsub;
        w1 = kwin_q[223:192] ^ w0;
        w2 = kwin_q[191:160] ^ w1;
        w3 = kwin_q[159:128] ^ w2;
    end

    always_comb begin
        state_d    = state_q;
        st_d       = st_q;
        kwin_d     = kwin_q;
        rnd_d      = rnd_q;
        rcon_idx_d = rcon_idx_q;
        dataout_d  = dataout_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    st_d       = datain ^ key[255:128];
                    kwin_d     = key;
                    rnd_d      = 4'd1;
                    rcon_idx_d = 4'd1;
                    state_d    = StRun;
                end
            end
            StRun: begin
                st_d   = rnd_out;
                kwin_d = {kwin_q[127:0], w0, w1, w2, w3};
                rnd_d  = rnd_q + 4'd1;
                if (rnd_q[0]) rcon_idx_d = rcon_idx_q + 4'd1;
                if (last) begin
                    dataout_d = rnd_out;
                    rnd_d     = 4'd0;
                    state_d   = StDone;
                end
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            st_q       <= '0;
            kwin_q     <= '0;
            rnd_q      <= '0;
            rcon_idx_q <= '0;
            dataout_q  <= '0;
        end else begin
            state_q    <= state_d;
            st_q       <= st_d;
            kwin_q     <= kwin_d;
            rnd_q      <= rnd_d;
            rcon_idx_q <= rcon_idx_d;
            dataout_q  <= dataout_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign dataout   = dataout_q;

endmodule

// File: tb/tb_aes256_encipher_iter.sv
// Self-checking bench for aes256_encipher_iter: known-answer vectors, handshake corner cases,
// and random blocks checked against a byte-array AES-256 cipher/inverse-cipher model.
module tb_aes256_encipher_iter;

    logic         clk, rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [127:0] datain, dataout;
    logic [255:0] key;
    int           cyc, checks, failures;

    localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C3_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] SP_KEY = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] SP_PT  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] SP_CT  = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;

    aes256_encipher_iter #(.NR(14)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .datain(datain), .key(key), .out_valid(out_valid), .out_ready(out_ready),
        .dataout(dataout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    logic [7:0]  sbt [256];
    logic [7:0]  isbt [256];
    logic [31:0] wk [60];

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 0; x = a; y = b;
        while (y != 0) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic void build_sbox();
        logic [7:0] c63 = 8'h63;
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv, s;
            inv = 0;
            for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c63[i];
            sbt[x]  = s;
            isbt[s] = 8'(x);
        end
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbt[w[31:24]], sbt[w[23:16]], sbt[w[15:8]], sbt[w[7:0]]};
    endfunction

    function automatic void expand(input logic [255:0] k);
        logic [31:0] tmp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) wk[i] = k[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            tmp = wk[i-1];
            if (i % 8 == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = gm(rc, 8'h02);
            end else if (i % 8 == 4) begin
                tmp = subw(tmp);
            end
            wk[i] = wk[i-8] ^ tmp;
        end
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [255:0] k);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [127:0] o;
        expand(k);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) s[r][c] = pt[127-8*(r+4*c) -: 8] ^ wk[c][31-8*r -: 8];
        for (int rd = 1; rd <= 14; rd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) t[r][c] = sbt[s[r][(c+r)%4]];
            if (rd < 14) begin
                for (int c = 0; c < 4; c++) begin
                    s[0][c] = gm(t[0][c], 2) ^ gm(t[1][c], 3) ^ t[2][c] ^ t[3][c];
                    s[1][c] = t[0][c] ^ gm(t[1][c], 2) ^ gm(t[2][c], 3) ^ t[3][c];
                    s[2][c] = t[0][c] ^ t[1][c] ^ gm(t[2][c], 2) ^ gm(t[3][c], 3);
                    s[3][c] = gm(t[0][c], 3) ^ t[1][c] ^ t[2][c] ^ gm(t[3][c], 2);
                end
            end else s = t;
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) s[r][c] = s[r][c] ^ wk[4*rd+c][31-8*r -: 8];
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) o[127-8*(r+4*c) -: 8] = s[r][c];
        return o;
    endfunction

    function automatic logic [127:0] aes_dec(input logic [127:0] ct, input logic [255:0] k);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [127:0] o;
        expand(k);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) s[r][c] = ct[127-8*(r+4*c) -: 8] ^ wk[56+c][31-8*r -: 8];
        for (int rd = 13; rd >= 0; rd--) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][(c+r)%4] = isbt[s[r][c]] ^ wk[4*rd+(c+r)%4][31-8*r -: 8];
            if (rd > 0) begin
                for (int c = 0; c < 4; c++) begin
                    s[0][c] = gm(t[0][c], 14) ^ gm(t[1][c], 11) ^ gm(t[2][c], 13) ^ gm(t[3][c], 9);
                    s[1][c] = gm(t[0][c], 9) ^ gm(t[1][c], 14) ^ gm(t[2][c], 11) ^ gm(t[3][c], 13);
                    s[2][c] = gm(t[0][c], 13) ^ gm(t[1][c], 9) ^ gm(t[2][c], 14) ^ gm(t[3][c], 11);
                    s[3][c] = gm(t[0][c], 11) ^ gm(t[1][c], 13) ^ gm(t[2][c], 9) ^ gm(t[3][c], 14);
                end
            end else s = t;
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) o[127-8*(r+4*c) -: 8] = s[r][c];
        return o;
    endfunction

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Returns the cycle stamp of the accepting edge.
    task automatic wait_accept(output int t);
        bit ok;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            ok = in_ready;
            tick();
            if (ok) break;
        end
        t = cyc;
        chk("accept_seen", 128'(ok), 128'd1);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        chk("done_seen", 128'(out_valid), 128'd1);
    endtask

    task automatic send(input logic [127:0] pt, input logic [255:0] k);
        int t;
        datain   = pt;
        key      = k;
        in_valid = 1'b1;
        wait_accept(t);
        in_valid = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n, t1, t2;
        bit seen;
        logic [127:0] pt, ct;
        logic [255:0] k;
        checks = 0; failures = 0; cyc = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; datain = '0; key = '0;
        build_sbox();
        chk("model_c3", aes_enc(C3_PT, C3_KEY), C3_CT);
        chk("model_sp", aes_enc(SP_PT, SP_KEY), SP_CT);

        #1;
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_dataout", dataout, 128'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // FIPS-197 C.3, consumer always ready: one-cycle out_valid pulse
        send(C3_PT, C3_KEY);
        wait_done(n);
        chk("c3_latency", 128'(n), 128'd14);
        chk("c3_dataout", dataout, C3_CT);
        tick();
        chk("c3_pulse_end", 128'(out_valid), 128'd0);
        chk("c3_in_ready", 128'(in_ready), 128'd1);

        // SP800-38A vector with 20 cycles of backpressure and junk inputs
        out_ready = 1'b0;
        send(SP_PT, SP_KEY);
        wait_done(n);
        chk("sp_dataout", dataout, SP_CT);
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'($urandom);
            datain   = {$urandom, $urandom, $urandom, $urandom};
            key      = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            tick();
            chk("stall_out_valid", 128'(out_valid), 128'd1);
            chk("stall_in_ready", 128'(in_ready), 128'd0);
            chk("stall_dataout", dataout, SP_CT);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("release_out_valid", 128'(out_valid), 128'd0);
        chk("release_in_ready", 128'(in_ready), 128'd1);
        chk("release_dataout", dataout, SP_CT);

        // Back-to-back with in_valid held high: second vector waits for the first to drain
        datain = C3_PT; key = C3_KEY; in_valid = 1'b1;
        wait_accept(t1);
        datain = SP_PT; key = SP_KEY;
        wait_done(n);
        chk("b2b_first", dataout, C3_CT);
        wait_accept(t2);
        in_valid = 1'b0;
        chk("b2b_spacing", 128'(t2 - t1), 128'd16);
        wait_done(n);
        chk("b2b_second", dataout, SP_CT);
        tick();

        // Reset during round 7, then a clean C.3 run
        send(C3_PT, C3_KEY);
        repeat (6) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 128'(in_ready), 128'd1);
        chk("midrst_out_valid", 128'(out_valid), 128'd0);
        chk("midrst_dataout", dataout, 128'd0);
        #2;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) seen = 1;
        end
        chk("midrst_no_spurious", 128'(seen), 128'd0);
        send(C3_PT, C3_KEY);
        wait_done(n);
        chk("midrst_latency", 128'(n), 128'd14);
        chk("midrst_c3", dataout, C3_CT);
        tick();

        // Random round-trip through the inverse-cipher model
        for (int i = 0; i < 200; i++) begin
            pt = {$urandom, $urandom, $urandom, $urandom};
            k  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            send(pt, k);
            wait_done(n);
            ct = dataout;
            chk("rand_ct", ct, aes_enc(pt, k));
            chk("rand_roundtrip", aes_dec(ct, k), pt);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes256_encipher_iter.md
Name: aes256_encipher_iter

Overview:
- Iterative AES-256 encryption core (FIPS-197) that pairs with the existing AES-256 decipher to form the encrypt/decrypt path.
- Executes one round per clock: 14 rounds after an initial AddRoundKey.
- Expands the key on the fly with a 256-bit sliding window, so there is no 15-entry round-key array.
- Valid/ready handshake on input, valid/ready handshake with hold on output.

Parameters:
- NR, 14, number of rounds. Fixed for AES-256; any other value is illegal and the bench checks only 14.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  datain/key valid
- in_ready  out  1  core idle and able to accept
- datain  in  128  plaintext; [127:120] is byte 0 (s0,0), column-major
- key  in  256  cipher key; [255:248] is key byte 0
- out_valid  out  1  dataout holds the ciphertext
- out_ready  in  1  consumer accepts dataout
- dataout  out  128  ciphertext, same byte order as datain

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, dataout=0, round counter=0, key window=0, rcon index=0.
- FSM IDLE:
  - in_ready=1.
  - On in_valid&in_ready edge: st <= datain ^ key[255:128]; kwin <= key; rnd <= 1; rcon index <= 1; go to RUN.
  - datain and key are sampled only at this edge; later changes are ignored.
- FSM RUN: in_ready=0. Each edge applies round rnd to st.
  - Round key is always kwin[127:0].
  - Rounds 1..13: SubBytes, ShiftRows, MixColumns, AddRoundKey.
  - Round 14: SubBytes, ShiftRows, AddRoundKey (no MixColumns).
  - Same edge: kwin <= {kwin[127:0], next4}, where next4 is four words w0..w3:
    - t = kwin[31:0].
    - Odd rnd: t' = SubWord(RotWord(t)) ^ {rcon,24'h0}; rcon index then increments.
    - Even rnd: t' = SubWord(t).
    - w0 = kwin[255:224]^t'; w1 = kwin[223:192]^w0; w2 = kwin[191:160]^w1; w3 = kwin[159:128]^w2.
  - rcon sequence: 01,02,04,08,10,20,40. Only indices 1..7 are used.
  - On the round-14 edge: dataout <= result, out_valid <= 1, go to DONE.
  - rnd increments each edge.
- Latency: exactly 14 clk edges from the accepting edge to out_valid=1.
- FSM DONE:
  - out_valid=1; dataout stable; in_ready=0.
  - On out_valid&out_ready edge: out_valid <= 0, go to IDLE. dataout keeps its value until the next completion.
- Throughput: at most one block per 16 cycles. No accept in the same cycle as the output handshake; in_ready rises the cycle after.
- Boundaries:
  - in_valid is ignored in RUN and DONE. No buffering and no error flag.
  - out_ready held high before completion: output is taken on the first cycle out_valid=1, so out_valid is a one-cycle pulse.
  - out_ready low indefinitely: the core stalls in DONE; no overwrite.
  - rst_n asserted mid-RUN or in DONE: immediate return to reset values; the partial result is discarded; no out_valid.
  - Counter wrap: rnd never exceeds NR.
- S-box is combinational (16 instances for SubBytes, 4 for SubWord). No memories.
- Pure synchronous datapath; no combinational path from in_valid to in_ready.

Test Plan:
- FIPS-197 C.3 vector:
  - Stimulus: key=000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, datain=00112233445566778899aabbccddeeff, out_ready=1.
  - Required: dataout=8ea2b7ca516745bfeafc49904b496089; out_valid exactly 14 edges after accept.
- SP800-38A ECB-AES256 vector:
  - Stimulus: key=603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, datain=6bc1bee22e409f96e93d7e117393172a.
  - Required: dataout=f3eed1bdb5d2a03c064b5a7e3db181f8.
- Output backpressure:
  - Stimulus: out_ready=0 for 20 cycles after completion; toggle datain/key/in_valid during the stall.
  - Required: out_valid stays 1; dataout unchanged; in_ready=0. out_ready=1 then gives out_valid=0 and in_ready=1 the next cycle.
- Reset mid-operation:
  - Stimulus: drop rst_n at round 7, release it, then submit the C.3 vector.
  - Required: outputs return to reset values asynchronously; no spurious out_valid; the correct C.3 ciphertext follows.
- Back-to-back blocks:
  - Stimulus: both vectors queued with in_valid held high.
  - Required: each accepted only when in_ready=1; results in order; 16-cycle spacing.
- Round-trip:
  - Stimulus: 200 random key/plaintext pairs through this core into the AES-256 decipher.
  - Required: recovered plaintext equals the input in every case.
